// File: rtl/stream_min_max.sv
// Streaming signed min/max/count reducer over a valid/ready burst, with a
// registered result presented on a valid/ready output handshake.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         lt_o
);
    assign lt_o = $signed(a_i) < $signed(b_i);
endmodule

module stream_min_max #(
    parameter int N       = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_min,
    output logic [N-1:0]       out_max,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_saturated
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       min_q, min_d;
    logic [N-1:0]       max_q, max_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               sat_q, sat_d;

    logic accept;
    logic data_lt_min;
    logic max_lt_data;

    comparator_lt #(.N(N)) u_lt_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .lt_o (data_lt_min)
    );

    comparator_lt #(.N(N)) u_lt_max (
        .a_i  (max_q),
        .b_i  (in_data),
        .lt_o (max_lt_data)
    );

    assign in_ready = (state_q != S_DONE);
    assign accept   = in_valid & in_ready;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        sat_d   = sat_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = COUNT_W'(1);
                    sat_d   = 1'b0;
                    state_d = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (data_lt_min) min_d = in_data;
                    if (max_lt_data) max_d = in_data;
                    // Count sticks at all-ones; the attempted overflow is remembered in sat.
                    if (&count_q) sat_d = 1'b1;
                    else          count_d = count_q + COUNT_W'(1);
                    if (in_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid     = (state_q == S_DONE);
    assign out_min       = min_q;
    assign out_max       = max_q;
    assign out_count     = count_q;
    assign out_saturated = sat_q;
endmodule

// File: tb/tb_stream_min_max.sv
// Bench for stream_min_max: directed burst table, hand-written corner sequences,
// and randomized bursts checked against a queue-based reference model.

module tb_stream_min_max;
    localparam int N  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_count;
    logic          out_saturated;

    int total = 0;
    int bad   = 0;

    stream_min_max #(.N(N), .COUNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_min       (out_min),
        .out_max       (out_max),
        .out_count     (out_count),
        .out_saturated (out_saturated)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          len;
        logic [31:0] d [4];
        logic [31:0] emin;
        logic [31:0] emax;
        int          ecnt;
        bit          esat;
    } vec_t;

    vec_t tbl [4];

    // Reference: min/max over the whole burst as signed integers, count clipped at all-ones.
    function automatic void model(input logic [31:0] s[$], output logic [31:0] mn,
                                  output logic [31:0] mx, output int cnt, output bit sat);
        int lim;
        lim = (1 << CW) - 1;
        mn  = s[0];
        mx  = s[0];
        foreach (s[i]) begin
            if ($signed(s[i]) < $signed(mn)) mn = s[i];
            if ($signed(s[i]) > $signed(mx)) mx = s[i];
        end
        cnt = (s.size() > lim) ? lim : s.size();
        sat = (s.size() > lim);
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit last, input bit stalls);
        int waited;
        if (stalls) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                in_data  = $urandom;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_burst(input logic [31:0] s[$], input bit stalls);
        foreach (s[i]) send_beat(s[i], (i == s.size() - 1), stalls);
    endtask

    // Called #1 after the edge that accepted the last beat.
    task automatic finish_burst(input string name, input logic [31:0] emin, input logic [31:0] emax,
                                input int ecnt, input bit esat, input int hold);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_min"},   out_min, emin);
        check({name, "_max"},   out_max, emax);
        check({name, "_count"}, 32'(out_count), 32'(ecnt));
        check({name, "_sat"},   32'(out_saturated), 32'(esat));
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_min"},   out_min, emin);
            check({name, "_hold_max"},   out_max, emax);
            check({name, "_hold_count"}, 32'(out_count), 32'(ecnt));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_pop_valid"}, 32'(out_valid), 32'd0);
        check({name, "_pop_ready"}, 32'(in_ready), 32'd1);
        check({name, "_pop_count"}, 32'(out_count), 32'd0);
        check({name, "_pop_sat"},   32'(out_saturated), 32'd0);
        check({name, "_pop_min"},   out_min, emin);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] emin, emax;
        int          ecnt;
        bit          esat;

        tbl[0].len = 4; tbl[0].d = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd7};
        tbl[0].emin = 32'hFFFF_FFFD; tbl[0].emax = 32'd7; tbl[0].ecnt = 4; tbl[0].esat = 1'b0;
        tbl[1].len = 1; tbl[1].d = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
        tbl[1].emin = 32'h8000_0000; tbl[1].emax = 32'h8000_0000; tbl[1].ecnt = 1; tbl[1].esat = 1'b0;
        tbl[2].len = 2; tbl[2].d = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
        tbl[2].emin = 32'h8000_0000; tbl[2].emax = 32'h7FFF_FFFF; tbl[2].ecnt = 2; tbl[2].esat = 1'b0;
        tbl[3].len = 3; tbl[3].d = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        tbl[3].emin = 32'hFFFF_FFFF; tbl[3].emax = 32'd0; tbl[3].ecnt = 3; tbl[3].esat = 1'b0;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_min",   out_min, 32'd0);
        check("reset_max",   out_max, 32'd0);
        check("reset_count", 32'(out_count), 32'd0);
        check("reset_sat",   32'(out_saturated), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed table; the first entry also holds the result for 5 cycles with in_valid high.
        for (int i = 0; i < 4; i++) begin
            q.delete();
            for (int k = 0; k < tbl[i].len; k++) q.push_back(tbl[i].d[k]);
            send_burst(q, 1'b0);
            finish_burst($sformatf("tbl%0d", i), tbl[i].emin, tbl[i].emax,
                         tbl[i].ecnt, tbl[i].esat, (i == 0) ? 5 : 0);
        end

        // Reset in the middle of a burst discards it.
        send_beat(32'd10, 1'b0, 1'b0);
        send_beat(32'd20, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_min",   out_min, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        q.push_back(32'd1);
        q.push_back(32'd2);
        send_burst(q, 1'b0);
        finish_burst("postrst", 32'd1, 32'd2, 2, 1'b0, 0);

        // 17 random beats: count saturates at F and the sticky flag is set.
        q.delete();
        for (int k = 0; k < 17; k++) q.push_back($urandom);
        send_burst(q, 1'b0);
        model(q, emin, emax, ecnt, esat);
        check("sat17_count_f", 32'(out_count), 32'hF);
        check("sat17_flag",    32'(out_saturated), 32'd1);
        finish_burst("sat17", emin, emax, ecnt, esat, 1);

        // Random bursts with stalls, ignored in_last beats, ties and output back-pressure.
        for (int b = 0; b < 30; b++) begin
            int len;
            len = $urandom_range(1, 20);
            q.delete();
            for (int k = 0; k < len; k++) begin
                if (b % 2 == 0) q.push_back(32'($signed($urandom_range(0, 6)) - 3));
                else            q.push_back($urandom);
            end
            send_burst(q, 1'b1);
            model(q, emin, emax, ecnt, esat);
            finish_burst($sformatf("rnd%0d", b), emin, emax, ecnt, esat, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
